// File: rtl/i2c_reg_target.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_reg_target
//  Purpose  : I2C target with a pointer-addressed byte register bank,
//             auto-increment bursts and repeated-START support.
//  Revision : 1.0
// ============================================================================
module i2c_reg_target #(
    parameter logic [6:0] I2C_ADDR    = 7'h2A,
    parameter int         NUM_REGS    = 8,
    parameter int         SYNC_STAGES = 2,
    localparam int        PTR_W       = ($clog2(NUM_REGS) < 1) ? 1 : $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_i,
    output logic                  scl_o,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic [NUM_REGS*8-1:0] regs_o,
    output logic                  wr_stb_o,
    output logic [PTR_W-1:0]      wr_ptr_o,
    output logic                  busy_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK
    } state_t;

    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_d, r_sda_d;
    logic                   w_scl, w_sda;
    logic                   w_scl_rise, w_scl_fall, w_start, w_stop;

    state_t                 r_state, w_state_nxt;
    logic [3:0]             r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]             r_shift, w_shift_nxt;
    logic [PTR_W-1:0]       r_ptr, w_ptr_nxt, w_ptr_inc;
    logic                   r_sda_o, w_sda_o_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_rw, w_rw_nxt;
    logic                   r_wr_stb;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic                   w_wr_en;
    logic [7:0]             w_byte, w_rd_byte;
    logic [7:0]             r_regs [NUM_REGS];

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_d;
    assign w_scl_fall = ~w_scl & r_scl_d;
    assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

    assign w_byte     = {r_shift[6:0], w_sda};
    assign w_rd_byte  = r_regs[r_ptr];
    assign w_ptr_inc  = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + PTR_W'(1);

    // Synchronisers reset to the idle-bus level so reset never fakes a START/STOP
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_d    <= w_scl;
            r_sda_d    <= w_sda;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_o_nxt   = r_sda_o;
        w_busy_nxt    = r_busy;
        w_rw_nxt      = r_rw;
        w_wr_en       = 1'b0;

        if (w_start) begin
            w_state_nxt   = S_ADDR;
            w_bit_cnt_nxt = 4'd0;
            w_sda_o_nxt   = 1'b1;
            w_busy_nxt    = 1'b0;
        end else if (w_stop) begin
            w_state_nxt = S_IDLE;
            w_sda_o_nxt = 1'b1;
        end else begin
            case (r_state)
                S_ADDR, S_PTR, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt = 4'd0;
                            if (r_state == S_ADDR) begin
                                if (w_byte[7:1] == I2C_ADDR) begin
                                    w_rw_nxt    = w_byte[0];
                                    w_state_nxt = S_ADDR_ACK;
                                end else begin
                                    w_state_nxt = S_IDLE;
                                end
                            end else if (r_state == S_PTR) begin
                                if ({1'b0, w_byte} < 9'(NUM_REGS)) begin
                                    w_ptr_nxt   = w_byte[PTR_W-1:0];
                                    w_state_nxt = S_PTR_ACK;
                                end else begin
                                    w_state_nxt = S_IDLE;
                                end
                            end else begin
                                w_wr_en     = 1'b1;
                                w_ptr_nxt   = w_ptr_inc;
                                w_state_nxt = S_WDATA_ACK;
                            end
                        end
                    end
                end
                // First fall opens the ACK window (SDA still released), second closes it
                S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (r_sda_o) begin
                            w_sda_o_nxt = 1'b0;
                            if (r_state == S_ADDR_ACK) w_busy_nxt = 1'b1;
                        end else if (r_state == S_ADDR_ACK && r_rw) begin
                            w_shift_nxt   = w_rd_byte;
                            w_sda_o_nxt   = w_rd_byte[7];
                            w_bit_cnt_nxt = 4'd0;
                            w_state_nxt   = S_RDATA;
                        end else begin
                            w_sda_o_nxt   = 1'b1;
                            w_bit_cnt_nxt = 4'd0;
                            w_state_nxt   = (r_state == S_ADDR_ACK) ? S_PTR : S_WDATA;
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_o_nxt = 1'b1;
                            w_state_nxt = S_RDATA_ACK;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_sda_o_nxt = r_shift[6];
                        end
                    end
                end
                S_RDATA_ACK: begin
                    if (w_scl_rise) begin
                        if (w_sda) w_state_nxt = S_IDLE;
                        else       w_ptr_nxt   = w_ptr_inc;
                    end else if (w_scl_fall) begin
                        w_shift_nxt   = w_rd_byte;
                        w_sda_o_nxt   = w_rd_byte[7];
                        w_bit_cnt_nxt = 4'd0;
                        w_state_nxt   = S_RDATA;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        if (w_state_nxt == S_IDLE) w_busy_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'd0;
            r_ptr     <= '0;
            r_sda_o   <= 1'b1;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_wr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_o   <= w_sda_o_nxt;
            r_busy    <= w_busy_nxt;
            r_rw      <= w_rw_nxt;
            r_wr_stb  <= w_wr_en;
            if (w_wr_en) r_wr_ptr <= r_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'd0;
        end else if (w_wr_en) begin
            r_regs[r_ptr] <= w_byte;
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        assign regs_o[8*gi +: 8] = r_regs[gi];
    end

    assign scl_o    = 1'b1;
    assign sda_o    = r_sda_o;
    assign busy_o   = r_busy;
    assign wr_stb_o = r_wr_stb;
    assign wr_ptr_o = r_wr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_i2c_reg_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_reg_target
//  Purpose  : Bit-banged I2C master driving i2c_reg_target, queue-based checks.
//  Revision : 1.0
// ============================================================================
module tb_i2c_reg_target;

    localparam int NUM_REGS = 8;
    localparam int Q        = 10;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  m_scl, m_sda;
    logic                  sda_bus;
    logic                  scl_o, sda_o, wr_stb_o, busy_o;
    logic [NUM_REGS*8-1:0] regs_o;
    logic [2:0]            wr_ptr_o;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_regs [NUM_REGS];
    logic [63:0] exp_q [$];
    logic [10:0] wr_q [$];

    assign sda_bus = m_sda & sda_o;

    always #5 clk = ~clk;

    i2c_reg_target #(
        .I2C_ADDR    (7'h2A),
        .NUM_REGS    (NUM_REGS),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .scl_i    (m_scl),
        .scl_o    (scl_o),
        .sda_i    (sda_bus),
        .sda_o    (sda_o),
        .regs_o   (regs_o),
        .wr_stb_o (wr_stb_o),
        .wr_ptr_o (wr_ptr_o),
        .busy_o   (busy_o)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_vec();
        logic [63:0] v;
        for (int i = 0; i < NUM_REGS; i++) v[8*i +: 8] = exp_regs[i];
        return v;
    endfunction

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b0; qwait();
        m_scl = 1'b0; qwait();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; qwait();
        m_scl = 1'b1; qwait();
        m_sda = 1'b1; qwait();
        qwait();
    endtask

    task automatic write_byte(input logic [7:0] b, input logic exp_ack);
        logic got;
        exp_q.push_back(64'(exp_ack));
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; qwait();
            m_scl = 1'b1; qwait();
            qwait();
            m_scl = 1'b0; qwait();
        end
        m_sda = 1'b1; qwait();
        m_scl = 1'b1; qwait();
        got = sda_bus; qwait();
        m_scl = 1'b0; qwait();
        check_val("ack", 64'(got), exp_q.pop_front());
    endtask

    task automatic write_data(input logic [2:0] ptr, input logic [7:0] b);
        wr_q.push_back({ptr, b});
        exp_regs[ptr] = b;
        write_byte(b, 1'b0);
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic m_ack);
        logic [7:0] d;
        exp_q.push_back(64'(exp));
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            qwait();
            m_scl = 1'b1; qwait();
            d[i] = sda_bus; qwait();
            m_scl = 1'b0; qwait();
        end
        m_sda = m_ack; qwait();
        m_scl = 1'b1; qwait();
        qwait();
        m_scl = 1'b0; qwait();
        m_sda = 1'b1;
        check_val("rdata", 64'(d), exp_q.pop_front());
    endtask

    // Every write strobe must match the oldest expected bank write
    always @(negedge clk) begin
        if (!reset && wr_stb_o) begin
            if (wr_q.size() == 0) begin
                check_val("wr_unexpected", 64'(wr_ptr_o), 64'hFF);
            end else begin
                logic [10:0] e;
                e = wr_q.pop_front();
                check_val("wr_ptr", 64'(wr_ptr_o), 64'(e[10:8]));
                check_val("wr_data", 64'(regs_o[int'(e[10:8])*8 +: 8]), 64'(e[7:0]));
            end
        end
    end

    initial begin
        reset = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'd0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("rst_sda", 64'(sda_o), 64'd1);
        check_val("rst_scl", 64'(scl_o), 64'd1);
        check_val("rst_regs", regs_o, 64'd0);
        check_val("rst_stb", 64'(wr_stb_o), 64'd0);
        check_val("rst_busy", 64'(busy_o), 64'd0);

        // single write to reg 3
        i2c_start();
        write_byte(8'h54, 1'b0);
        check_val("busy_addr", 64'(busy_o), 64'd1);
        write_byte(8'h03, 1'b0);
        write_data(3'd3, 8'hA5);
        i2c_stop();
        check_val("busy_stop", 64'(busy_o), 64'd0);
        check_val("reg3", 64'(regs_o[31:24]), 64'hA5);
        check_val("wr_pend1", 64'(wr_q.size()), 64'd0);

        // burst wrapping from the last register to reg 0
        i2c_start();
        write_byte(8'h54, 1'b0);
        write_byte(8'h07, 1'b0);
        write_data(3'd7, 8'h11);
        write_data(3'd0, 8'h22);
        i2c_stop();
        check_val("regs_wrap", regs_o, model_vec());
        check_val("wr_pend2", 64'(wr_q.size()), 64'd0);

        i2c_start();
        write_byte(8'h54, 1'b0);
        write_byte(8'h04, 1'b0);
        write_data(3'd4, 8'h5C);
        i2c_stop();

        // pointer set, repeated START, burst read with ACK then NACK
        i2c_start();
        write_byte(8'h54, 1'b0);
        write_byte(8'h03, 1'b0);
        i2c_start();
        write_byte(8'h55, 1'b0);
        read_byte(8'hA5, 1'b0);
        read_byte(8'h5C, 1'b1);
        check_val("rd_release", 64'(sda_o), 64'd1);
        check_val("rd_busy", 64'(busy_o), 64'd0);
        i2c_stop();

        // foreign address is ignored
        i2c_start();
        write_byte(8'h56, 1'b1);
        check_val("busy_foreign", 64'(busy_o), 64'd0);
        write_byte(8'h03, 1'b1);
        write_byte(8'h99, 1'b1);
        i2c_stop();
        check_val("regs_foreign", regs_o, model_vec());

        // out-of-range pointer is refused
        i2c_start();
        write_byte(8'h54, 1'b0);
        write_byte(8'h09, 1'b1);
        check_val("busy_badptr", 64'(busy_o), 64'd0);
        write_byte(8'h77, 1'b1);
        i2c_stop();
        check_val("regs_badptr", regs_o, model_vec());

        // reset while driving a read bit low
        i2c_start();
        write_byte(8'h54, 1'b0);
        write_byte(8'h00, 1'b0);
        i2c_start();
        write_byte(8'h55, 1'b0);
        check_val("rd_bit7_low", 64'(sda_o), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check_val("mid_rst_sda", 64'(sda_o), 64'd1);
        check_val("mid_rst_regs", regs_o, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) exp_regs[i] = 8'd0;
        m_sda = 1'b1;
        m_scl = 1'b1;
        qwait();
        check_val("mid_rst_busy", 64'(busy_o), 64'd0);

        i2c_start();
        write_byte(8'h54, 1'b0);
        write_byte(8'h02, 1'b0);
        write_data(3'd2, 8'h3C);
        i2c_stop();
        check_val("regs_after_rst", regs_o, model_vec());
        check_val("wr_pend_end", 64'(wr_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
